frv_cf_arbiter: RTL

FRV_CF_ARBITER -- requirements
Module: frv_cf_arbiter

---
 rtl/frv_cf_arbiter_pkg.sv | 18 +
 rtl/frv_cf_arbiter_if.sv | 54 +++++
 rtl/frv_cf_arbiter_prio_sel.sv | 28 ++
 rtl/frv_cf_arbiter.sv | 124 ++++++++++++
 4 files changed

// File: rtl/frv_cf_arbiter_pkg.sv
// frv_cf_arbiter_pkg -- shared definitions for the control-flow arbiter.
//   cf_state_e : arbiter FSM states (IDLE waits for requesters, BUSY holds a grant)
//   CF_SRC_*   : source ids driven on cf_src
//   STARVE_W   : width of the interrupt starvation counter
package frv_cf_arbiter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } cf_state_e;

  localparam logic [1:0] CF_SRC_WB  = 2'd0;
  localparam logic [1:0] CF_SRC_IRQ = 2'd1;
  localparam logic [1:0] CF_SRC_DBG = 2'd2;

  localparam int unsigned STARVE_W = 4;

endpackage

// File: rtl/frv_cf_arbiter_if.sv
// frv_cf_arbiter_if -- control-flow request bundle between requesters,
// the arbiter and fetch.
//   wb_cf_*  : writeback-stage request / target / completion pulse
//   irq_cf_* : interrupt-controller request / target / completion pulse
//   dbg_cf_* : debug request channel, present only with FRV_CF_ARB_DEBUG_EN
//   cf_req / cf_target / cf_src : arbitrated request towards fetch
//   cf_ack   : fetch accepted the current cf_req
// Modports: slave = arbiter view, master = requester/fetch environment view.
interface frv_cf_arbiter_if #(
  parameter int unsigned XLEN = 32
) ();

  logic            wb_cf_req;
  logic [XLEN-1:0] wb_cf_target;
  logic            wb_cf_ack;

  logic            irq_cf_req;
  logic [XLEN-1:0] irq_cf_target;
  logic            irq_cf_ack;

`ifdef FRV_CF_ARB_DEBUG_EN
  logic            dbg_cf_req;
  logic [XLEN-1:0] dbg_cf_target;
  logic            dbg_cf_ack;
`endif

  logic            cf_req;
  logic [XLEN-1:0] cf_target;
  logic [1:0]      cf_src;
  logic            cf_ack;

`ifdef FRV_CF_ARB_DEBUG_EN
  modport slave (
    input  wb_cf_req, wb_cf_target, irq_cf_req, irq_cf_target,
           dbg_cf_req, dbg_cf_target, cf_ack,
    output wb_cf_ack, irq_cf_ack, dbg_cf_ack, cf_req, cf_target, cf_src
  );
  modport master (
    output wb_cf_req, wb_cf_target, irq_cf_req, irq_cf_target,
           dbg_cf_req, dbg_cf_target, cf_ack,
    input  wb_cf_ack, irq_cf_ack, dbg_cf_ack, cf_req, cf_target, cf_src
  );
`else
  modport slave (
    input  wb_cf_req, wb_cf_target, irq_cf_req, irq_cf_target, cf_ack,
    output wb_cf_ack, irq_cf_ack, cf_req, cf_target, cf_src
  );
  modport master (
    output wb_cf_req, wb_cf_target, irq_cf_req, irq_cf_target, cf_ack,
    input  wb_cf_ack, irq_cf_ack, cf_req, cf_target, cf_src
  );
`endif

endinterface

// File: rtl/frv_cf_arbiter_prio_sel.sv
// frv_cf_prio_sel -- combinational winner selection for the control-flow
// arbiter. Priority dbg > wb > irq, except a starved irq beats wb.
//   wb_req / irq_req / dbg_req : live request lines
//   irq_starved                : irq has lost STARVE_LIMIT arbitrations in a row
//   any_req                    : at least one request present
//   winner                     : CF_SRC_* id of the winning requester
module frv_cf_prio_sel
  import frv_cf_arbiter_pkg::*;
(
  input  logic       wb_req,
  input  logic       irq_req,
  input  logic       dbg_req,
  input  logic       irq_starved,
  output logic       any_req,
  output logic [1:0] winner
);

  always_comb begin
    any_req = wb_req | irq_req | dbg_req;
    winner  = CF_SRC_WB;
    if (dbg_req) begin
      winner = CF_SRC_DBG;
    end else if (irq_req && (irq_starved || !wb_req)) begin
      winner = CF_SRC_IRQ;
    end
  end

endmodule

// File: rtl/frv_cf_arbiter.sv
// frv_cf_arbiter -- arbitrates control-flow redirect requests onto a single
// fetch request channel, with starvation protection for the interrupt path.
//   g_clk   : clock, all state on the rising edge
//   g_reset : asynchronous active-high reset
//   bus     : frv_cf_arbiter_if.slave (requesters, fetch request and ack)
// Parameters: XLEN target width, STARVE_LIMIT (1..15) lost irq arbitrations
// before irq is promoted above wb.
// Macro FRV_CF_ARB_DEBUG_EN adds the debug channel at highest priority;
// without it arbitration is two-way and cf_src is never 2.
module frv_cf_arbiter
  import frv_cf_arbiter_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic               g_clk,
  input  logic               g_reset,
  frv_cf_arbiter_if.slave    bus
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  cf_state_e           state_q, state_d;
  logic [1:0]          src_q;
  logic [XLEN-1:0]     tgt_q;
  logic [STARVE_W-1:0] starve_q, starve_d;

  logic                dbg_req;
  logic                any_req;
  logic [1:0]          winner;
  logic                grant;
  logic [XLEN-1:0]     grant_tgt;
  logic                wb_ack, irq_ack, dbg_ack;

`ifdef FRV_CF_ARB_DEBUG_EN
  assign dbg_req = bus.dbg_cf_req;
`else
  assign dbg_req = 1'b0;
`endif

  frv_cf_prio_sel u_prio_sel (
    .wb_req      (bus.wb_cf_req),
    .irq_req     (bus.irq_cf_req),
    .dbg_req     (dbg_req),
    .irq_starved (starve_q == LIMIT),
    .any_req     (any_req),
    .winner      (winner)
  );

  always_comb begin
    grant_tgt = bus.wb_cf_target;
    if (winner == CF_SRC_IRQ) begin
      grant_tgt = bus.irq_cf_target;
    end
`ifdef FRV_CF_ARB_DEBUG_EN
    if (winner == CF_SRC_DBG) begin
      grant_tgt = bus.dbg_cf_target;
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    grant    = 1'b0;
    wb_ack   = 1'b0;
    irq_ack  = 1'b0;
    dbg_ack  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          state_d = ST_BUSY;
          grant   = 1'b1;
        end
        // Starvation is only tracked at grant opportunities, i.e. in IDLE.
        if (bus.irq_cf_req && winner != CF_SRC_IRQ) begin
          if (starve_q < LIMIT) begin
            starve_d = starve_q + 1'b1;
          end
        end else begin
          starve_d = '0;
        end
      end
      ST_BUSY: begin
        if (bus.cf_ack) begin
          state_d = ST_IDLE;
          wb_ack  = (src_q == CF_SRC_WB);
          irq_ack = (src_q == CF_SRC_IRQ);
          dbg_ack = (src_q == CF_SRC_DBG);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge g_clk or posedge g_reset) begin
    if (g_reset) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      tgt_q    <= '0;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      if (grant) begin
        src_q <= winner;
        tgt_q <= grant_tgt;
      end
    end
  end

  assign bus.cf_req     = (state_q == ST_BUSY);
  assign bus.cf_target  = tgt_q;
  assign bus.cf_src     = src_q;
  assign bus.wb_cf_ack  = wb_ack;
  assign bus.irq_cf_ack = irq_ack;
`ifdef FRV_CF_ARB_DEBUG_EN
  assign bus.dbg_cf_ack = dbg_ack;
`else
  logic unused_dbg_ack;
  assign unused_dbg_ack = dbg_ack;
`endif

endmodule
